uart_tx_fifo: RTL and testbench



---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered UART transmitter with CTS gating and optional even parity
module uart_tx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_baud,
    output logic                          o_baud_en,
    input  logic [DATA_WIDTH-1:0]         i_din,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_busy,
    input  logic                          i_cts_n,
    output logic                          o_TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q;
    logic                  full, empty, push, pop;

    logic                  cts_meta_q, cts_sync_q;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_q, par_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  load_q, load_d;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = i_valid && !full;

    assign o_ready      = !full;
    assign o_fifo_count = count_q;
    assign o_busy       = (state_q != IDLE);

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // CTS idles "not clear" so nothing leaves before the far end is known ready
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= i_cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        load_d    = load_q;
        pop       = 1'b0;
        o_TX      = 1'b1;
        o_baud_en = 1'b1;
        case (state_q)
            IDLE: begin
                o_baud_en = 1'b0;
                // the popped word spends one cycle in the shift register before START
                if (load_q) begin
                    load_d  = 1'b0;
                    state_d = START;
                end else if (!empty && !cts_sync_q) begin
                    pop     = 1'b1;
                    load_d  = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    par_d   = ^mem_q[rd_ptr_q];
                end
            end
            START: begin
                o_TX = 1'b0;
                if (i_baud) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                o_TX = shift_q[0];
                if (i_baud) begin
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == 4'(DATA_WIDTH - 1)) begin
                        cnt_d   = '0;
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                o_TX = par_q;
                if (i_baud) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end
            STOP: begin
                if (i_baud) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == 4'(STOP_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo with line decoder and FIFO model
module tb_uart_tx_fifo;
    localparam int DW = 8, PE = 1, SB = 2, DEPTH = 16;
    localparam int NBITS = 1 + DW + PE + SB;

    logic       clk = 1'b0;
    logic       rst, baud, baud_en, valid, ready, busy, cts_n, tx;
    logic [7:0] din;
    logic [4:0] count;

    int checks = 0, failures = 0;
    int div = 8;
    int bcnt = 0;
    int max_count = 0;

    int rx_data[$], rx_par[$], rx_ok[$], rx_gap[$];
    int exp_q[$];
    int held = 0;

    always #5 clk = ~clk;

    // baud generator: restarts when disabled, one tick per div cycles
    always @(posedge clk) begin
        if (!baud_en)             bcnt <= 0;
        else if (bcnt == div - 1) bcnt <= 0;
        else                      bcnt <= bcnt + 1;
    end
    assign baud = baud_en && (bcnt == div - 1);

    always @(negedge clk) begin
        if (int'(count) > max_count) max_count <= int'(count);
    end

    uart_tx_fifo #(
        .DATA_WIDTH(DW), .PARITY_EN(PE), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_baud(baud), .o_baud_en(baud_en),
        .i_din(din), .i_valid(valid), .o_ready(ready), .o_fifo_count(count),
        .o_busy(busy), .i_cts_n(cts_n), .o_TX(tx)
    );

    // line decoder: every bit must hold its value for exactly div cycles
    initial begin : monitor
        int idle;
        logic [NBITS-1:0] bits;
        bit stable, abort;
        idle = 1000;
        forever begin
            @(negedge clk);
            if (rst || tx !== 1'b0) begin
                idle++;
                continue;
            end
            stable = 1'b1;
            abort  = 1'b0;
            bits   = '0;
            for (int b = 0; b < NBITS && !abort; b++) begin
                for (int k = 0; k < div; k++) begin
                    if (!(b == 0 && k == 0)) @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                    if (k == 0) bits[b] = tx;
                    else if (tx !== bits[b]) stable = 1'b0;
                end
            end
            if (!abort) begin
                rx_data.push_back(int'(bits[DW:1]));
                rx_par.push_back(int'(bits[DW+1]));
                rx_ok.push_back((stable && bits[0] == 1'b0 && bits[NBITS-1 -: SB] == '1) ? 1 : 0);
                rx_gap.push_back(idle);
            end
            idle = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d);
        din   = d;
        valid = 1'b1;
        if (held < DEPTH) begin
            exp_q.push_back(int'(d));
            held++;
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n);
        int t = 0;
        int budget = n * (NBITS * div + 10) + 100;
        while (rx_data.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_frames"}, rx_data.size(), n);
    endtask

    task automatic wait_start(input string tag);
        int t = 0;
        while (tx !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_start"}, tx, 1'b0);
    endtask

    task automatic compare(input string tag, input bit gaps);
        int n;
        logic [7:0] d;
        n = exp_q.size();
        check({tag, "_count"}, rx_data.size(), n);
        for (int i = 0; i < n && i < rx_data.size(); i++) begin
            d = exp_q[i][7:0];
            check($sformatf("%s_data%0d", tag, i), rx_data[i], exp_q[i]);
            check($sformatf("%s_par%0d", tag, i), rx_par[i], ^d);
            check($sformatf("%s_fmt%0d", tag, i), rx_ok[i], 1);
            if (gaps && i > 0) check($sformatf("%s_gap%0d", tag, i), rx_gap[i], 2);
        end
        rx_data.delete(); rx_par.delete(); rx_ok.delete(); rx_gap.delete();
        exp_q.delete();
        held = 0;
    endtask

    initial begin
        int n, total, lat;
        rst = 1'b1; valid = 1'b0; din = '0; cts_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_baud_en", baud_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", count, 0);
        check("rst_ready", ready, 1'b1);
        rst = 1'b0;

        // single frame with realistic divisor and push-to-START latency
        div = 217;
        cts_n = 1'b0;
        repeat (4) @(negedge clk);
        push(8'hA6);
        check("lat_count_n", count, 1);
        check("lat_tx_n", tx, 1'b1);
        check("lat_ben_n", baud_en, 1'b0);
        held = 0;
        @(negedge clk);
        check("lat_count_n1", count, 0);
        check("lat_tx_n1", tx, 1'b1);
        check("lat_busy_n1", busy, 1'b0);
        @(negedge clk);
        check("lat_tx_n2", tx, 1'b0);
        check("lat_busy_n2", busy, 1'b1);
        check("lat_ben_n2", baud_en, 1'b1);
        wait_frames("single", 1);
        @(negedge clk);
        check("single_busy_end", busy, 1'b0);
        check("single_tx_end", tx, 1'b1);
        compare("single", 1'b0);

        // parity values
        div = 8;
        push(8'h37);
        push(8'hFF);
        wait_frames("parity", 2);
        check("par_37", rx_par[0], 1);
        check("par_ff", rx_par[1], 0);
        compare("parity", 1'b0);

        // FIFO full with CTS held off
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i <= DEPTH; i++) begin
            push(8'(i));
            check($sformatf("full_ready%0d", i), ready, (i < DEPTH - 1) ? 1'b1 : 1'b0);
            check($sformatf("full_count%0d", i), count, (i < DEPTH) ? i + 1 : DEPTH);
        end
        check("full_model", exp_q.size(), DEPTH);
        cts_n = 1'b0;
        wait_frames("full", DEPTH);
        repeat (3 * NBITS * div) @(negedge clk);
        check("full_count_end", count, 0);
        compare("full", 1'b1);

        // CTS withdrawn mid-frame
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) push(8'($urandom));
        cts_n = 1'b0;
        wait_start("cts");
        repeat (3 * div) @(negedge clk);
        cts_n = 1'b1;
        repeat (4 * NBITS * div) @(negedge clk);
        check("cts_one_frame", rx_data.size(), 1);
        check("cts_held", count, 2);
        check("cts_idle_tx", tx, 1'b1);
        cts_n = 1'b0;
        lat = 0;
        while (tx !== 1'b0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("cts_latency", lat, 4);
        wait_frames("cts", 3);
        compare("cts", 1'b0);

        // reset in the middle of a frame
        cts_n = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) push(8'($urandom));
        cts_n = 1'b0;
        wait_start("rstmid");
        repeat (3 * div) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_tx", tx, 1'b1);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_count", count, 0);
        check("rstmid_ben", baud_en, 1'b0);
        check("rstmid_ready", ready, 1'b1);
        rst = 1'b0;
        repeat (5 * NBITS * div) @(negedge clk);
        check("rstmid_no_frames", rx_data.size(), 0);
        rx_data.delete(); rx_par.delete(); rx_ok.delete(); rx_gap.delete();
        exp_q.delete();
        held = 0;

        // pointer wrap: random bursts totalling 40 words
        total = 0;
        while (total < 40) begin
            n = $urandom_range(1, DEPTH);
            if (n > 40 - total) n = 40 - total;
            cts_n = 1'b1;
            repeat (4) @(negedge clk);
            for (int i = 0; i < n; i++) begin
                if (total + i == 0)      push(8'h00);
                else if (total + i == 1) push(8'hFF);
                else                     push(8'($urandom));
            end
            check($sformatf("wrap_count%0d", total), count, n);
            cts_n = 1'b0;
            wait_frames("wrap", n);
            compare($sformatf("wrap%0d", total), 1'b1);
            total += n;
        end
        check("max_count", (max_count <= DEPTH) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
